// File: rtl/uart_mem_link_if.sv
// Signal bundle between uart_mem_link, the CPU memory port and the UART
// transceiver FIFOs. The slave modport is the bridge's view.
interface uart_mem_link_if;
  // CPU request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Transceiver FIFOs
  logic        uart_send_flag;
  logic [7:0]  uart_send_data;
  logic        uart_sendable;
  logic        uart_recv_flag;
  logic [7:0]  uart_recv_data;
  logic        uart_receivable;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    input  uart_sendable, uart_recv_data, uart_receivable,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output uart_send_flag, uart_send_data, uart_recv_flag
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    output uart_sendable, uart_recv_data, uart_receivable,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  uart_send_flag, uart_send_data, uart_recv_flag
  );
endinterface

// File: rtl/uart_mem_link.sv
// uart_mem_link: turns one 32-bit CPU memory request into a UART byte packet
// (header, address, optional write data) and assembles the host's reply
// (4 read-data bytes or a 1-byte write ack) into a single-cycle response.
// Stale reply bytes are flushed while idle or sending; a silent host fails
// the request after TIMEOUT_CYCLES.
module uart_mem_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic           CLK,
  input  logic           RST,
  uart_mem_link_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HDR,
    S_SEND_ADDR,
    S_SEND_DATA,
    S_RECV,
    S_DONE
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        tmo_q, tmo_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        send_flag_q, send_flag_d;
  logic [7:0]  send_data_q, send_data_d;
  logic        recv_flag_q, recv_flag_d;

  logic        accept;
  logic        in_send;
  logic        push;
  logic        pop;
  logic        capture;
  logic [7:0]  tx_byte;

  assign accept  = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign in_send = (state_q == S_SEND_HDR) || (state_q == S_SEND_ADDR) ||
                   (state_q == S_SEND_DATA);
  // A push or pop is never issued on the cycle right after another one, so
  // the transceiver FIFO flags have a cycle to settle.
  assign push    = in_send && bus.uart_sendable && !send_flag_q;
  // Pops run in every state but DONE: in RECV they capture reply bytes,
  // elsewhere they flush stale replies of earlier timed-out requests.
  assign pop     = (state_q != S_DONE) && bus.uart_receivable && !recv_flag_q;
  assign capture = pop && (state_q == S_RECV);

  // Byte of the packet belonging to the current send state and counter.
  always_comb begin
    tx_byte = '0;
    unique case (state_q)
      S_SEND_HDR:  tx_byte = {write_q, 3'b000, mask_q};
      S_SEND_ADDR: tx_byte = addr_q[{cnt_q, 3'b000} +: 8];
      S_SEND_DATA: tx_byte = wdata_q[{cnt_q, 3'b000} +: 8];
      default:     tx_byte = '0;
    endcase
  end

  // Next-state, counters, request/reply datapath and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    tmo_d        = tmo_q;
    tcnt_d       = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    send_flag_d  = push;
    send_data_d  = push ? tx_byte : send_data_q;
    recv_flag_d  = pop;
    // Low on the accept edge and during DONE, so it rises one cycle after
    // the resp_valid pulse.
    req_ready_d  = (state_q == S_IDLE) && !accept;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND_HDR;
          cnt_d   = '0;
          write_d = bus.req_write;
          mask_d  = bus.req_mask;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rbuf_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      S_SEND_HDR: begin
        if (push) begin
          state_d = S_SEND_ADDR;
          cnt_d   = '0;
        end
      end
      S_SEND_ADDR: begin
        if (push) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = write_q ? S_SEND_DATA : S_RECV;
            cnt_d   = '0;
          end
        end
      end
      S_SEND_DATA: begin
        if (push) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_RECV;
            cnt_d   = '0;
          end
        end
      end
      S_RECV: begin
        if (capture) begin
          rbuf_d[{cnt_q, 3'b000} +: 8] = bus.uart_recv_data;
          tcnt_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (write_q || (cnt_q == 2'd3)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else if (tcnt_q == TMO_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = (write_q || tmo_q) ? '0 : rbuf_q;
        resp_err_d   = tmo_q || (write_q && (rbuf_q[7:0] != 8'h00));
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; RST abandons any packet in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      tmo_q        <= 1'b0;
      tcnt_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      send_flag_q  <= 1'b0;
      send_data_q  <= '0;
      recv_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      tmo_q        <= tmo_d;
      tcnt_q       <= tcnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      send_flag_q  <= send_flag_d;
      send_data_q  <= send_data_d;
      recv_flag_q  <= recv_flag_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.uart_send_flag = send_flag_q;
  assign bus.uart_send_data = send_data_q;
  assign bus.uart_recv_flag = recv_flag_q;

endmodule

// File: tb/tb_uart_mem_link.sv
// Testbench for uart_mem_link: table of request/packet/reply vectors plus
// hand-written sequences for timeout, stale flush, sendable stalls and
// mid-packet reset. Cycle k is the cycle starting at clock edge k.
module tb_uart_mem_link;

  localparam int HIST = 4096;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_mem_link_if bus ();

  uart_mem_link #(.TIMEOUT_CYCLES(50)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic            wr;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0]      mask;
    logic [0:8][7:0] pkt;
    int              npkt;
    logic [0:3][7:0] rep;
    int              nrep;
    logic [31:0]     rdata;
    logic            err;
  } vec_t;

  vec_t vt [5];

  int n_chk  = 0;
  int n_fail = 0;

  // Environment bookkeeping (written only by the environment process)
  int         cyc = 0;
  int         viol = 0;
  int         pops = 0;
  int         resp_cnt = 0;
  int         resp_cyc = 0;
  int         last_pop_cyc = 0;
  int         acc_cnt = 0;
  int         acc_edge = 0;
  int         rd_ptr = 0;
  logic [7:0] sent_b [$];
  int         sent_c [$];
  bit         ready_hist [HIST];
  logic       fl_last = 1'b0;
  logic       sd_last = 1'b1;
  // Host reply bytes (written only by the stimulus process)
  logic [7:0] host_q [$];
  bit         rand_sd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Transceiver model: logs pushes, serves host bytes as a fall-through FIFO,
  // drives uart_sendable, and records handshake/response timing.
  initial begin
    bus.uart_sendable   = 1'b1;
    bus.uart_receivable = 1'b0;
    bus.uart_recv_data  = 8'h00;
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      ready_hist[(cyc - 1) % HIST] = bus.req_ready;
      if (bus.uart_send_flag) begin
        sent_b.push_back(bus.uart_send_data);
        sent_c.push_back(cyc - 1);
        if (fl_last) viol++;
        if (!sd_last) viol++;
      end
      fl_last = bus.uart_send_flag;
      sd_last = bus.uart_sendable;
      if (bus.uart_recv_flag) begin
        last_pop_cyc = cyc - 1;
        pops++;
        if (rd_ptr < host_q.size()) rd_ptr++;
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc - 1;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt++;
        acc_edge = cyc;
      end
      #1;
      bus.uart_sendable   = rand_sd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.uart_receivable = (rd_ptr < host_q.size());
      bus.uart_recv_data  = bus.uart_receivable ? host_q[rd_ptr] : 8'h00;
    end
  end

  task automatic do_req(input vec_t v, input string tag);
    int n;
    int base;
    n    = 0;
    base = acc_cnt;
    @(negedge CLK);
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_mask  = v.mask;
    bus.req_valid = 1'b1;
    while (acc_cnt == base && n < 100) begin
      @(negedge CLK);
      n++;
    end
    bus.req_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(acc_cnt - base), 32'd1);
  endtask

  task automatic wait_sent(input int base, input int need);
    int n;
    n = 0;
    while ((sent_b.size() - base) < need && n < 400) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic wait_resp(input int base);
    int n;
    n = 0;
    while (resp_cnt == base && n < 400) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit timing, input string tag);
    int sbase;
    int rbase;
    sbase = sent_b.size();
    rbase = resp_cnt;
    do_req(v, tag);
    wait_sent(sbase, v.npkt);
    chk({tag, "_nbytes"}, 32'(sent_b.size() - sbase), 32'(v.npkt));
    for (int i = 0; i < v.npkt; i++) begin
      if (sbase + i < sent_b.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), 32'(sent_b[sbase + i]), 32'(v.pkt[i]));
        if (timing)
          chk($sformatf("%s_cyc%0d", tag, i), 32'(sent_c[sbase + i] - acc_edge), 32'(2 * i + 1));
      end
    end
    for (int i = 0; i < v.nrep; i++) host_q.push_back(v.rep[i]);
    wait_resp(rbase);
    repeat (3) @(negedge CLK);
    chk({tag, "_one_resp"}, 32'(resp_cnt - rbase), 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, v.rdata);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(v.err));
    chk({tag, "_resp_lat"}, 32'(resp_cyc - last_pop_cyc), 32'd1);
    chk({tag, "_rdy_during"}, 32'(ready_hist[resp_cyc % HIST]), 32'd0);
    chk({tag, "_rdy_after"}, 32'(ready_hist[(resp_cyc + 1) % HIST]), 32'd1);
  endtask

  initial begin
    int   rbase;
    int   pbase;
    int   sbase;
    int   c2;
    int   n;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;

    //        wr    addr          wdata         mask  packet bytes in send order                                       n  reply                               n  rdata         err
    vt[0] = '{1'b0, 32'h8000_1234, 32'h0000_0000, 4'hF, {8'h0F, 8'h34, 8'h12, 8'h00, 8'h80, 32'h0},                      5, {8'h78, 8'h56, 8'h34, 8'h12}, 4, 32'h1234_5678, 1'b0};
    vt[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, {8'h83, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 9, {8'h00, 24'h0},                1, 32'h0000_0000, 1'b0};
    vt[2] = '{1'b1, 32'h0000_0004, 32'h0102_0304, 4'hF, {8'h8F, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01}, 9, {8'h55, 24'h0},                1, 32'h0000_0000, 1'b1};
    vt[3] = '{1'b0, 32'hA5A5_0001, 32'h0000_0000, 4'h1, {8'h01, 8'h01, 8'h00, 8'hA5, 8'hA5, 32'h0},                      5, {8'hEF, 8'hCD, 8'hAB, 8'h89}, 4, 32'h89AB_CDEF, 1'b0};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, {8'h80, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 9, {8'hFF, 24'h0},                1, 32'h0000_0000, 1'b1};

    // Reset values while RST is held
    repeat (3) @(negedge CLK);
    chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_send_flag",  32'(bus.uart_send_flag), 32'd0);
    chk("rst_send_data",  32'(bus.uart_send_data), 32'd0);
    chk("rst_recv_flag",  32'(bus.uart_recv_flag), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Table of complete transactions with sendable held high
    for (int unsigned i = 0; i < 5; i++) run_vec(vt[i], 1'b1, $sformatf("v%0d", i));

    // Timeout: host goes silent after two of the four read bytes
    rbase = resp_cnt;
    sbase = sent_b.size();
    do_req(vt[3], "tmo");
    wait_sent(sbase, 5);
    pbase = pops;
    host_q.push_back(8'h11);
    host_q.push_back(8'h22);
    n = 0;
    while (pops - pbase < 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_two_pops", 32'(pops - pbase), 32'd2);
    c2 = last_pop_cyc;
    wait_resp(rbase);
    repeat (2) @(negedge CLK);
    chk("tmo_one_resp", 32'(resp_cnt - rbase), 32'd1);
    // DONE is entered 50 cycles after the last capture edge; resp_valid
    // follows one cycle later, as on the normal path.
    chk("tmo_latency", 32'(resp_cyc - c2), 32'd51);
    chk("tmo_err",   32'(bus.resp_err), 32'd1);
    chk("tmo_rdata", bus.resp_rdata, 32'd0);

    // Late bytes of the failed read arrive while idle and are discarded
    rbase = resp_cnt;
    pbase = pops;
    host_q.push_back(8'h33);
    host_q.push_back(8'h44);
    repeat (12) @(negedge CLK);
    chk("flush_pops",    32'(pops - pbase), 32'd2);
    chk("flush_drained", 32'(host_q.size() - rd_ptr), 32'd0);
    chk("flush_no_resp", 32'(resp_cnt - rbase), 32'd0);
    chk("flush_ready",   32'(bus.req_ready), 32'd1);
    run_vec(vt[0], 1'b1, "post_tmo");

    // Write with uart_sendable toggling pseudo-randomly
    rand_sd = 1'b1;
    run_vec(vt[1], 1'b0, "rnd");
    rand_sd = 1'b0;
    chk("rnd_push_rule", 32'(viol), 32'd0);

    // Reset after the third byte of a write, then a clean read
    sbase = sent_b.size();
    rbase = resp_cnt;
    do_req(vt[4], "rst");
    wait_sent(sbase, 3);
    chk("rst_third_byte", 32'(bus.uart_send_data), 32'hFF);
    RST = 1'b1;
    #1;
    chk("mid_req_ready",  32'(bus.req_ready), 32'd1);
    chk("mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_resp_err",   32'(bus.resp_err), 32'd0);
    chk("mid_resp_rdata", bus.resp_rdata, 32'd0);
    chk("mid_send_flag",  32'(bus.uart_send_flag), 32'd0);
    chk("mid_send_data",  32'(bus.uart_send_data), 32'd0);
    chk("mid_recv_flag",  32'(bus.uart_recv_flag), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("mid_no_resp",   32'(resp_cnt - rbase), 32'd0);
    chk("mid_no_push",   32'(sent_b.size() - sbase), 32'd3);
    run_vec(vt[3], 1'b1, "post_rst");

    chk("push_rule_total", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case a stimulus step stalls beyond its own bounds
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
